// File: rtl/shift_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | shift_pkg : shared types for the shift_arbiter block                |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} shift_dir_t;

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_if.sv
// +--------------------------------------------------------------------+
// | shift_arbiter_if : request/response bus between clients and arbiter |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

interface shift_arbiter_if #(
  parameter int N = 3,
  parameter int R = 4
);
  localparam int DW  = 2**N;
  localparam int IDW = $clog2(R);

  logic [R-1:0]         req_valid;
  logic [R-1:0]         req_ready;
  logic [R-1:0][DW-1:0] req_data;
  logic [R-1:0][N-1:0]  req_amt;
  logic [R-1:0]         req_dir;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DW-1:0]        resp_data;
  logic [IDW-1:0]       resp_id;

  modport master (
    output req_valid, req_data, req_amt, req_dir, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

`default_nettype wire

// File: rtl/shift_arbiter_rr_grant.sv
// +--------------------------------------------------------------------+
// | rr_grant : combinational round-robin search starting at ptr         |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_grant #(
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin : p_search
    logic [IDW-1:0] idx;
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = R - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % R);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter_shifters.sv
// +--------------------------------------------------------------------+
// | param_left_shifter / param_right_shifter : 2**N-bit barrel rotators |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module param_left_shifter #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] data,
  input  logic [N-1:0]    amt,
  output logic [2**N-1:0] result
);
  localparam int DW = 2**N;

  // Shifting a doubled copy makes the wrapped bits fall out of the top half.
  logic [2*DW-1:0] w_dbl;

  assign w_dbl  = {data, data} << amt;
  assign result = w_dbl[2*DW-1:DW];

endmodule

module param_right_shifter #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] data,
  input  logic [N-1:0]    amt,
  output logic [2**N-1:0] result
);
  localparam int DW = 2**N;

  logic [2*DW-1:0] w_dbl;

  assign w_dbl  = {data, data} >> amt;
  assign result = w_dbl[DW-1:0];

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// +--------------------------------------------------------------------+
// | shift_arbiter : round-robin sharing of one rotate datapath by R     |
// | requesters, with a registered one-deep result stage.                |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = 3,
  parameter int R = 4
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  shift_arbiter_if.slave   bus
);
  localparam int DW  = 2**N;
  localparam int IDW = $clog2(R);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [DW-1:0]  r_resp_data;
  logic [IDW-1:0] r_resp_id;

  logic [R-1:0]   w_grant;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_any;
  logic           w_can_accept;
  logic           w_xfer;

  logic [DW-1:0]  w_sel_data;
  logic [N-1:0]   w_sel_amt;
  shift_dir_t     w_sel_dir;
  logic [DW-1:0]  w_rotl;
  logic [DW-1:0]  w_rotr;
  logic [DW-1:0]  w_result;

  rr_grant #(.R(R)) u_grant (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_sel_data = bus.req_data[w_gnt_idx];
  assign w_sel_amt  = bus.req_amt[w_gnt_idx];
  assign w_sel_dir  = shift_dir_t'(bus.req_dir[w_gnt_idx]);

  param_left_shifter #(.N(N)) u_lsh (
    .data   (w_sel_data),
    .amt    (w_sel_amt),
    .result (w_rotl)
  );

  param_right_shifter #(.N(N)) u_rsh (
    .data   (w_sel_data),
    .amt    (w_sel_amt),
    .result (w_rotr)
  );

  assign w_result = (w_sel_dir == DIR_RIGHT) ? w_rotr : w_rotl;

  // The result slot frees up in the same cycle the consumer takes it.
  assign w_can_accept  = (r_state == EMPTY) || bus.resp_ready;
  assign w_xfer        = w_any && w_can_accept && reset_n;
  assign bus.req_ready = (reset_n && w_can_accept) ? w_grant : '0;

  assign w_ptr_nxt = (w_gnt_idx == IDW'(R - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL:    if (!w_xfer && bus.resp_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_nxt;
      r_resp_data <= w_result;
      r_resp_id   <= w_gnt_idx;
    end
  end

  assign bus.resp_valid = (r_state == FULL);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.req_ready));

  a_stall_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (bus.resp_valid && !bus.resp_ready) |=>
      (bus.resp_valid && $stable(bus.resp_data) && $stable(bus.resp_id)));

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_shift_arbiter : scoreboard bench for shift_arbiter (N=3, R=4)    |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_shift_arbiter;
  localparam int N  = 3;
  localparam int R  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } resp_t;

  logic clk;
  logic reset_n;

  shift_arbiter_if #(.N(N), .R(R)) bus ();

  shift_arbiter #(.N(N), .R(R)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  resp_t        sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_ptr    = 0;
  bit           m_full   = 1'b0;
  logic [R-1:0] exp_ready = '0;

  // Bit-by-bit rotate reference.
  function automatic logic [7:0] rot(input logic [7:0] d, input int amt, input bit right);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < DW; i++) begin
      if (right) o[i] = d[(i + amt) % DW];
      else       o[(i + amt) % DW] = d[i];
    end
    return o;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input bit dir);
    bus.req_data[i] = d;
    bus.req_amt[i]  = a;
    bus.req_dir[i]  = dir;
  endtask

  // One cycle of stimulus; the arbitration model decides what gets accepted.
  task automatic drive(input logic [R-1:0] rv, input bit rr);
    int g;
    bit can;
    @(posedge clk);
    #1;
    bus.req_valid  = rv;
    bus.resp_ready = rr;
    can = !m_full || rr;
    g = -1;
    for (int k = R - 1; k >= 0; k--) begin
      if (rv[(m_ptr + k) % R]) g = (m_ptr + k) % R;
    end
    exp_ready = '0;
    if (g >= 0 && can) begin
      exp_ready[g] = 1'b1;
      sb.push_back(resp_t'({2'(g), rot(bus.req_data[g], int'(bus.req_amt[g]), bus.req_dir[g])}));
      m_ptr  = (g + 1) % R;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr     = 0;
    m_full    = 1'b0;
    exp_ready = '0;
  endtask

  // Scoreboard: req_ready every cycle, results popped as they are consumed.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      if (bus.req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL req_ready: got %b expected %b at %0t", bus.req_ready, exp_ready, $time);
      end
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin : b_pop
        resp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got id %0d data %h expected no response at %0t",
                   bus.resp_id, bus.resp_data, $time);
        end else begin
          e = sb.pop_front();
          if ({bus.resp_id, bus.resp_data} !== e) begin
            n_fail++;
            $display("FAIL resp_sb: got id %0d data %h expected id %0d data %h at %0t",
                     bus.resp_id, bus.resp_data, e.id, e.data, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b id %0d data %h expected all zero",
               bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_left();
    set_req(0, 8'b1000_0001, 3'd1, 1'b0);
    drive(4'b0001, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'd0, 8'b0000_0011}) begin
      n_fail++;
      $display("FAIL single_left: got v%b id %0d data %h expected v1 id 0 data 03",
               bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_clear: got resp_valid %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_single_right();
    set_req(2, 8'h01, 3'd3, 1'b1);
    drive(4'b0100, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'd2, 8'h20}) begin
      n_fail++;
      $display("FAIL single_right: got v%b id %0d data %h expected v1 id 2 data 20",
               bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    set_req(2, 8'hA5, 3'd0, 1'b1);
    drive(4'b0100, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'd2, 8'hA5}) begin
      n_fail++;
      $display("FAIL amt_zero: got v%b id %0d data %h expected v1 id 2 data a5",
               bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    drive(4'b0000, 1'b1);
  endtask

  task automatic test_round_robin();
    int ids[5] = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1 reset_n = 1'b1;
    set_req(0, 8'h12, 3'd7, 1'b0);
    set_req(1, 8'h34, 3'd2, 1'b1);
    set_req(2, 8'h56, 3'd5, 1'b0);
    set_req(3, 8'h78, 3'd4, 1'b1);
    drive(4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive((c < 4) ? 4'b1111 : 4'b0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(ids[c])) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got v%b id %0d expected v1 id %0d",
                 c, bus.resp_valid, bus.resp_id, ids[c]);
      end
    end
    drive(4'b0000, 1'b1);
  endtask

  task automatic test_backpressure();
    set_req(1, 8'h3C, 3'd0, 1'b0);
    drive(4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0101, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready} !==
          {1'b1, 2'd1, 8'h3C, 4'b0000}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v%b id %0d data %h ready %b expected v1 id 1 data 3c ready 0000",
                 c, bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready);
      end
    end
    drive(4'b0101, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_release: got ready %b expected 0100", bus.req_ready);
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL post_stall: got v%b id %0d expected v1 id 2", bus.resp_valid, bus.resp_id);
    end
    drive(4'b0000, 1'b1);
  endtask

  task automatic test_skip_wrap();
    logic [3:0] rvs[8] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000,
                           4'b0000, 4'b1111, 4'b1101, 4'b1000};
    int gnts[8] = '{3, 1, 3, -1, -1, 0, 2, 3};
    set_req(1, 8'h11, 3'd2, 1'b0);
    set_req(3, 8'hF0, 3'd7, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(rvs[k], 1'b1);
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (gnts[k-1] < 0) begin
          if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle[%0d]: got resp_valid %b expected 0", k, bus.resp_valid);
          end
        end else if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(gnts[k-1])) begin
          n_fail++;
          $display("FAIL skip_wrap[%0d]: got v%b id %0d expected v1 id %0d",
                   k, bus.resp_valid, bus.resp_id, gnts[k-1]);
        end
      end
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3) begin
      n_fail++;
      $display("FAIL skip_last: got v%b id %0d expected v1 id 3", bus.resp_valid, bus.resp_id);
    end
    drive(4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_req(0, 8'hC3, 3'd1, 1'b1);
    drive(4'b0001, 1'b1);
    drive(4'b0110, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_stall: got resp_valid %b expected 1", bus.resp_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v%b id %0d data %h ready %b expected all zero",
               bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    drive(4'b0110, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL post_reset_grant: got v%b id %0d expected v1 id 1", bus.resp_valid, bus.resp_id);
    end
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_amt    = '0;
    bus.req_dir    = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single_left();
    test_single_right();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
